spi_slave_v2: RTL and testbench

SPI mode-0 responder that lives on the far end of the team's SPI master link: it receives bytes on `mosi` and returns bytes on `miso` while its chip select is low. The external `sclk`, `cs_n` and `mosi` are treated as asynchronous to `clk`; they are synchronised and edge-detected internally. On the system side the block exposes a parallel byte interface: a valid/ready TX holding buffer, an RX strobe, and a per-frame status pulse.

---
 rtl/spi_slave_v2.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave_v2.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_v2.sv
// SPI mode-0 slave with synchronised pins, TX holding buffer,
// RX strobe and per-frame status (word count, partial, underrun).
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   sclk, cs_n, mosi    SPI pins from the master (asynchronous)
//   miso, miso_oe       SPI data back to the master and pad enable
//   tx_data/valid/ready host-side TX holding register handshake
//   rx_data, rx_valid   last complete word and its one-cycle strobe
//   busy                frame in progress
//   frame_done          one-cycle end-of-frame strobe
//   frame_words         complete words in the last frame (saturating)
//   frame_partial       last frame ended mid-word
//   tx_underrun         a word was sent from an empty holding register
module spi_slave_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_words,
  output logic                  frame_partial,
  output logic                  tx_underrun
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  // Pin synchronisers; index 0 is the first flop.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  // The cs_n chain resets low so that a cs_n still held low
  // when reset releases produces no falling edge; the rising
  // edge seen at power-up lands in IDLE and is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];

  state_e                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [CNT_WIDTH-1:0]  frame_words_q, frame_words_d;
  logic                  frame_partial_q, frame_partial_d;
  logic                  underrun_q, underrun_d;

  logic                  load;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rx_next;

  assign rx_next = {rx_shift_q[DATA_WIDTH-2:0], mosi_q[1]};
  assign accept  = tx_valid & ~hold_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      word_cnt_q      <= '0;
      tx_shift_q      <= '0;
      rx_shift_q      <= '0;
      hold_q          <= '0;
      hold_full_q     <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_words_q   <= '0;
      frame_partial_q <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      word_cnt_q      <= word_cnt_d;
      tx_shift_q      <= tx_shift_d;
      rx_shift_q      <= rx_shift_d;
      hold_q          <= hold_d;
      hold_full_q     <= hold_full_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      frame_done_q    <= frame_done_d;
      frame_words_q   <= frame_words_d;
      frame_partial_q <= frame_partial_d;
      underrun_q      <= underrun_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    word_cnt_d      = word_cnt_q;
    tx_shift_d      = tx_shift_q;
    rx_shift_d      = rx_shift_q;
    hold_d          = hold_q;
    hold_full_d     = hold_full_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    frame_done_d    = 1'b0;
    frame_words_d   = frame_words_q;
    frame_partial_d = frame_partial_q;
    underrun_d      = underrun_q;
    load            = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          load       = 1'b1;
        end
      end
      ACTIVE: begin
        // cs_rise takes priority over any sclk edge.
        if (cs_rise) begin
          state_d         = IDLE;
          frame_done_d    = 1'b1;
          frame_words_d   = word_cnt_q;
          frame_partial_d = (bit_cnt_q != '0);
          underrun_d      = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            if (word_cnt_q != '1) begin
              word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end else begin
            load = 1'b1;
          end
        end
      end
    endcase

    // A load always takes the pre-acceptance holding contents,
    // so a word accepted in the same cycle waits for the next load.
    if (load) begin
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = '1;
        underrun_d = 1'b1;
      end
    end

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  assign busy          = (state_q == ACTIVE);
  assign miso_oe       = busy;
  assign miso          = busy & tx_shift_q[DATA_WIDTH-1];
  assign tx_ready      = ~hold_full_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign frame_done    = frame_done_q;
  assign frame_words   = frame_words_q;
  assign frame_partial = frame_partial_q;
  assign tx_underrun   = underrun_q;

endmodule

// File: tb/tb_spi_slave_v2.sv
// Self-checking bench for spi_slave_v2: table of SPI frames
// plus hand-written reset sequences.
module tb_spi_slave_v2;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_done;
  logic [3:0] frame_words;
  logic       frame_partial;
  logic       tx_underrun;

  spi_slave_v2 #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_words  (frame_words),
    .frame_partial(frame_partial),
    .tx_underrun  (tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         nw;
    int         pb;
    logic [7:0] mbase;
    logic [7:0] tbase;
    int         ntx;
  } vec_t;

  vec_t vecs[7];

  int nvec = 0;
  int nerr = 0;
  int fd_cnt = 0;
  int frames_exp = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_exp[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Host side: offer queue head, pop on handshake.
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      if (tx_q.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = tx_q[0];
      end else begin
        tx_valid = 1'b0;
      end
      if (tx_valid && tx_ready && rst_n) begin
        @(posedge clk);
        #1;
        void'(tx_q.pop_front());
      end
    end
  end

  // RX scoreboard and frame_done counter.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (rx_exp.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL rx_unexpected: got strobe with %0h, required none",
                   rx_data);
        end else begin
          e = rx_exp.pop_front();
          chk("rx_data", rx_data, e);
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic sclk_bit(input logic b, output logic s);
    mosi = b;
    repeat (8) @(negedge clk);
    s = miso;
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] w;
    logic [7:0] got;
    logic [7:0] expm;
    logic       s;
    int         nb;
    int         found;
    int         ewords;
    logic [3:0] fw;
    logic       fp;
    fw = '0;
    fp = 1'b0;
    for (int i = 0; i < v.ntx; i++) begin
      w = v.tbase + 8'(i * 17);
      tx_q.push_back(w);
    end
    for (int i = 0; i < v.nw; i++) begin
      w = v.mbase + 8'(i);
      rx_exp.push_back(w);
    end
    repeat (4) @(negedge clk);
    chk("tx_ready_pre", tx_ready, v.ntx == 0);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_on", busy, 1);
    chk("miso_oe_on", miso_oe, 1);
    chk("tx_ready_after_load", tx_ready, v.ntx < 2);
    for (int i = 0; i <= v.nw; i++) begin
      nb = (i < v.nw) ? 8 : v.pb;
      if (nb == 0) break;
      w = v.mbase + 8'(i);
      got = '0;
      for (int b = 7; b >= 8 - nb; b--) begin
        sclk_bit(w[b], s);
        got[b] = s;
      end
      if (i < v.nw) begin
        expm = (i < v.ntx) ? v.tbase + 8'(i * 17) : 8'hFF;
        chk("miso_word", got, expm);
      end
    end
    repeat (8) @(negedge clk);
    chk("underrun_in_frame", tx_underrun, v.ntx < v.nw + 1);
    chk("rx_all_seen", rx_exp.size(), 0);
    cs_n = 1'b1;
    frames_exp++;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (frame_done) begin
        found = 1;
        fw = frame_words;
        fp = frame_partial;
      end
    end
    chk("frame_done_seen", found, 1);
    ewords = (v.nw > 15) ? 15 : v.nw;
    chk("frame_words", fw, ewords);
    chk("frame_partial", fp, v.pb != 0);
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 0);
    chk("frame_words_held", frame_words, ewords);
    chk("underrun_cleared", tx_underrun, 0);
    chk("busy_off", busy, 0);
    chk("miso_oe_off", miso_oe, 0);
    chk("miso_off", miso, 0);
    mosi = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_miso_oe"}, miso_oe, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_words"}, frame_words, 0);
    chk({tag, "_frame_partial"}, frame_partial, 0);
    chk({tag, "_tx_underrun"}, tx_underrun, 0);
  endtask

  initial begin
    logic s;
    vec_t post;
    vecs[0] = '{1, 0, 8'hA5, 8'h3C, 1};
    vecs[1] = '{3, 0, 8'h01, 8'h11, 3};
    vecs[2] = '{1, 0, 8'h5A, 8'h00, 0};
    vecs[3] = '{0, 5, 8'hE7, 8'h66, 1};
    vecs[4] = '{1, 0, 8'hC3, 8'h9A, 2};
    vecs[5] = '{2, 0, 8'h12, 8'h77, 1};
    vecs[6] = '{17, 0, 8'h40, 8'h05, 18};
    post    = '{1, 0, 8'h96, 8'h4B, 1};

    rst_n = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_no_frame", fd_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i]);
    end

    // Reset in the middle of a frame with cs_n left low.
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < 3; b++) sclk_bit(1'b1, s);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < 8; b++) sclk_bit(b[0], s);
    repeat (8) @(negedge clk);
    chk("held_cs_busy", busy, 0);
    chk("held_cs_oe", miso_oe, 0);
    chk("held_cs_rx", rx_data, 0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("reselect_idle", busy, 0);
    run_frame(post);

    chk("frame_done_count", fd_cnt, frames_exp);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
